counter_load_sequencer: RTL and testbench

Upstream command sequencer for the 4-bit loadable up/down counter. It accepts a queue of counting commands over a valid/ready handshake and buffers them in a small FIFO. Each command is turned into a one-cycle load of the counter's start value, followed by a timed run phase in a fixed direction. Its outputs drive the counter's `load` and `chnge` inputs directly. `busy` and `done` report status to the surrounding control logic.

---
 rtl/counter_load_sequencer.sv | 155 +++++++++++++++
 tb/tb_counter_load_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/counter_load_sequencer.sv
// Command sequencer for the 4-bit loadable up/down counter: a FIFO of commands,
// each issued as a one-cycle load followed by a timed run. Optional macro: CNT_SEQ_LOOP_EN.
module counter_load_sequencer #(
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 8
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_load,
  input  logic               cmd_dir,
  input  logic [DWELL_W-1:0] cmd_dwell,
`ifdef CNT_SEQ_LOOP_EN
  input  logic               loop,
`endif
  output logic [3:0]         load,
  output logic               load_en,
  output logic               chnge,
  output logic               busy,
  output logic               done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 5 + DWELL_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  logic [EW-1:0]      mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [EW-1:0]      act;
  logic [EW-1:0]      next_entry;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_next;
  state_t             state;
  state_t             state_next;
  logic               push;
  logic               pop;

  assign cmd_ready = (count != DEPTH_C);
  assign push      = cmd_valid && cmd_ready;

  // Next state, pop decision and dwell counter update.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    dwell_next = dwell_cnt;
    case (state)
      IDLE: begin
        if (count != {CW{1'b0}}) begin
          pop        = 1'b1;
          state_next = LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        // Zero dwell runs for one cycle, like dwell 1.
        if (act[DWELL_W-1:0] == {DWELL_W{1'b0}}) begin
          dwell_next = DWELL_W'(1);
        end else begin
          dwell_next = act[DWELL_W-1:0];
        end
        state_next = RUN;
      end
      RUN: begin
        if (dwell_cnt > DWELL_W'(1)) begin
          dwell_next = dwell_cnt - DWELL_W'(1);
          state_next = RUN;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
`ifdef CNT_SEQ_LOOP_EN
        if (loop && (count == {CW{1'b0}})) begin
          state_next = LOAD;
        end else begin
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // The command entering LOAD: the FIFO head on a pop, else the replayed active one.
  always_comb begin
    if (pop) begin
      next_entry = mem[rd_ptr];
    end else begin
      next_entry = act;
    end
  end

  // FIFO storage; contents need no reset because the pointers are cleared.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_load, cmd_dir, cmd_dwell};
    end
  end

  // Pointers, occupancy, FSM state and active command.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr    <= {PW{1'b0}};
      rd_ptr    <= {PW{1'b0}};
      count     <= {CW{1'b0}};
      state     <= IDLE;
      act       <= {EW{1'b0}};
      dwell_cnt <= {DWELL_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        act    <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      state     <= state_next;
      dwell_cnt <= dwell_next;
    end
  end

  // Registered outputs, computed from the state being entered.
  always_ff @(posedge CLK) begin
    if (reset) begin
      load    <= 4'd0;
      load_en <= 1'b0;
      chnge   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      load_en <= (state_next == LOAD);
      busy    <= (state_next != IDLE);
      done    <= (state_next == DONE);
      if (state_next == LOAD) begin
        load  <= next_entry[EW-1 -: 4];
        chnge <= next_entry[DWELL_W];
      end
    end
  end

endmodule

// File: tb/tb_counter_load_sequencer.sv
// Randomized and directed bench for counter_load_sequencer, checked against a
// timeline model: each command's pop cycle is derived from accept time and dwell.
module tb_counter_load_sequencer;

  localparam int DEPTH   = 4;
  localparam int DWELL_W = 8;

  logic               CLK = 1'b0;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [3:0]         cmd_load;
  logic               cmd_dir;
  logic [DWELL_W-1:0] cmd_dwell;
  logic               loop;
  logic [3:0]         load;
  logic               load_en;
  logic               chnge;
  logic               busy;
  logic               done;

  counter_load_sequencer #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_dir   (cmd_dir),
    .cmd_dwell (cmd_dwell),
`ifdef CNT_SEQ_LOOP_EN
    .loop      (loop),
`endif
    .load      (load),
    .load_en   (load_en),
    .chnge     (chnge),
    .busy      (busy),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         acc;
    int         pop;
    logic [3:0] ld;
    logic       dir;
    int         d;
  } cmd_t;

  cmd_t q[$];
  int   cyc;
  int   last_free;
  int   checks;
  int   errors;
  logic accepted;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Expected outputs for the current cycle, from each command's timeline.
  task automatic check_cycle();
    logic       e_le, e_busy, e_done, e_dir;
    logic [3:0] e_ld;
    int         occ;
    e_le = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_dir = 1'b0; e_ld = 4'd0; occ = 0;
    foreach (q[i]) begin
      if (q[i].pop == cyc) e_le = 1'b1;
      if (q[i].pop <= cyc && cyc < q[i].pop + 2 + q[i].d) e_busy = 1'b1;
      if (cyc == q[i].pop + 1 + q[i].d) e_done = 1'b1;
      if (q[i].pop <= cyc) begin
        e_ld  = q[i].ld;
        e_dir = q[i].dir;
      end
      if (q[i].acc <= cyc && cyc < q[i].pop) occ++;
    end
    chk("load_en", {3'd0, load_en}, {3'd0, e_le});
    chk("load", load, e_ld);
    chk("chnge", {3'd0, chnge}, {3'd0, e_dir});
    chk("busy", {3'd0, busy}, {3'd0, e_busy});
    chk("done", {3'd0, done}, {3'd0, e_done});
    chk("cmd_ready", {3'd0, cmd_ready}, {3'd0, (occ < DEPTH)});
  endtask

  function automatic bit model_ready();
    int occ = 0;
    foreach (q[i]) if (q[i].acc <= cyc && cyc < q[i].pop) occ++;
    return occ < DEPTH;
  endfunction

  // One clock cycle: check, drive, record any accept, advance.
  task automatic step(input logic v, input logic [3:0] l, input logic d,
                      input logic [DWELL_W-1:0] w, input logic r);
    cmd_t c;
    check_cycle();
    reset     = r;
    cmd_valid = v & ~r;
    cmd_load  = l;
    cmd_dir   = d;
    cmd_dwell = w;
    accepted  = 1'b0;
    if (v && !r && model_ready()) begin
      c.acc = cyc + 1;
      c.pop = (c.acc + 1 > last_free) ? c.acc + 1 : last_free;
      c.ld  = l;
      c.dir = d;
      c.d   = (w == '0) ? 1 : int'(w);
      last_free = c.pop + 3 + c.d;
      q.push_back(c);
      accepted = 1'b1;
    end
    @(posedge CLK);
    cyc++;
    if (r) begin
      q.delete();
      last_free = 0;
    end
    @(negedge CLK);
  endtask

  task automatic push_cmd(input logic [3:0] l, input logic d, input logic [DWELL_W-1:0] w);
    int n = 0;
    accepted = 1'b0;
    while (!accepted && n < 600) begin
      step(1'b1, l, d, w, 1'b0);
      n++;
    end
    checks++;
    if (!accepted) begin
      errors++;
      $error("FAIL push_timeout load %0d: observed not accepted expected accepted", l);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; last_free = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_load = 4'd0; cmd_dir = 1'b0;
    cmd_dwell = 8'd0; loop = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    idle(2);

    // Single command {12, 1, 5}.
    push_cmd(4'd12, 1'b1, 8'd5);
    idle(12);

    // Fill behind a long-running command; a fifth waits for space.
    push_cmd(4'd1, 1'b0, 8'd20);
    push_cmd(4'd3, 1'b1, 8'd2);
    push_cmd(4'd7, 1'b0, 8'd1);
    push_cmd(4'd11, 1'b1, 8'd3);
    push_cmd(4'd15, 1'b0, 8'd0);
    push_cmd(4'd2, 1'b1, 8'd4);
    idle(60);

    // Dwell extremes.
    push_cmd(4'd9, 1'b1, 8'd0);
    idle(6);
    push_cmd(4'd6, 1'b0, 8'd255);
    idle(265);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 4)), 1'b0);
    end
    idle(80);

    // Reset during RUN with two commands still queued.
    push_cmd(4'd13, 1'b1, 8'd10);
    push_cmd(4'd4, 1'b0, 8'd10);
    push_cmd(4'd8, 1'b1, 8'd10);
    idle(3);
    step(1'b0, 4'd0, 1'b0, 8'd0, 1'b1);
    idle(30);
    push_cmd(4'd10, 1'b1, 8'd2);
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
